// File: rtl/snap_log_pkg.sv
// Shared types for the snapshot change logger: verdict FSM encoding and log entry layout.
package snap_log_pkg;

  localparam int unsigned SNAP_DATA_W = 8;
  localparam int unsigned SNAP_TS_W   = 16;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ARMED = 3'd1,
    ST_MATCH = 3'd2,
    ST_STUCK = 3'd3,
    ST_WRONG = 3'd4
  } snap_state_e;

  typedef struct packed {
    logic [SNAP_TS_W-1:0]   ts;
    logic [SNAP_DATA_W-1:0] data;
  } snap_entry_t;

endpackage

// File: rtl/snap_fifo.sv
// FWFT ring buffer for change-log entries; define SNAP_DROP_OLDEST_EN to overwrite the
// oldest entry on a full push instead of dropping the new one.
module snap_fifo #(
  parameter int unsigned WIDTH = 24,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             drop_o
);

  localparam int unsigned AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    rd_q, rd_d, wr_q, wr_d;
  logic [AW:0]      cnt_q, cnt_d;
  logic             empty, full, do_pop, wr_en, push_acc;

  assign empty   = (cnt_q == '0);
  assign full    = (cnt_q == FULL_CNT);
  assign do_pop  = pop_i & ~empty;
  assign drop_o  = push_i & full & ~do_pop;
  assign valid_o = ~empty;
  assign full_o  = full;
  assign data_o  = empty ? '0 : mem_q[rd_q];

  always_comb begin
    rd_d     = rd_q;
    wr_d     = wr_q;
    cnt_d    = cnt_q;
    wr_en    = 1'b0;
    push_acc = 1'b0;
    if (do_pop) rd_d = rd_q + 1'b1;
    // A pop in the same cycle frees the slot the push needs, even when full.
    if (push_i && (!full || do_pop)) begin
      wr_en    = 1'b1;
      push_acc = 1'b1;
      wr_d     = wr_q + 1'b1;
    end
`ifdef SNAP_DROP_OLDEST_EN
    else if (push_i) begin
      wr_en = 1'b1;
      wr_d  = wr_q + 1'b1;
      rd_d  = rd_q + 1'b1;
    end
`endif
    case ({push_acc, do_pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      rd_q  <= rd_d;
      wr_q  <= wr_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_q] <= data_i;
  end

endmodule

// File: rtl/snap_change_logger.sv
// Logs every change of the captured snapshot word with a timestamp and judges the arm window.
// Optional build macro: SNAP_DROP_OLDEST_EN (passed through to the log FIFO).
module snap_change_logger
  import snap_log_pkg::*;
#(
  parameter int unsigned DATA_W      = SNAP_DATA_W,
  parameter int unsigned DEPTH       = 4,
  parameter int unsigned TS_W        = SNAP_TS_W,
  parameter int unsigned STUCK_LIMIT = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   arm_i,
  input  logic [DATA_W-1:0]      sample_i,
  input  logic [DATA_W-1:0]      expect_i,
  output logic                   out_valid_o,
  input  logic                   out_ready_i,
  output logic [TS_W+DATA_W-1:0] out_data_o,
  output logic [2:0]             state_o,
  output logic                   match_o,
  output logic                   stuck_o,
  output logic                   overflow_o
);

  localparam int unsigned WIN_W      = (STUCK_LIMIT > 1) ? $clog2(STUCK_LIMIT) : 1;
  localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(STUCK_LIMIT - 1);

  logic [TS_W-1:0]   ts_q;
  logic [DATA_W-1:0] sample_q;
  logic [DATA_W-1:0] expect_q, expect_d;
  logic [WIN_W-1:0]  win_q, win_d;
  logic              ovf_q, ovf_d;
  snap_state_e       state_q, state_d;

  logic              chg;
  logic              fifo_drop;
  logic              fifo_full;

  assign chg = (sample_i != sample_q);

  snap_fifo #(
    .WIDTH (TS_W + DATA_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (chg),
    .data_i  ({ts_q, sample_i}),
    .pop_i   (out_ready_i),
    .valid_o (out_valid_o),
    .data_o  (out_data_o),
    .full_o  (fifo_full),
    .drop_o  (fifo_drop)
  );

  always_comb begin
    state_d  = state_q;
    expect_d = expect_q;
    win_d    = win_q;
    if (arm_i) begin
      state_d  = ST_ARMED;
      expect_d = expect_i;
      win_d    = '0;
    end else begin
      case (state_q)
        ST_ARMED: begin
          win_d = win_q + 1'b1;
          // Match is checked first so a hit on the final window cycle still counts.
          if (sample_i == expect_q)  state_d = ST_MATCH;
          else if (win_q == WIN_LAST) state_d = (sample_i == '0) ? ST_STUCK : ST_WRONG;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    ovf_d = arm_i ? 1'b0 : ovf_q;
    if (fifo_drop) ovf_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ts_q     <= '0;
      sample_q <= '0;
      expect_q <= '0;
      win_q    <= '0;
      ovf_q    <= 1'b0;
      state_q  <= ST_IDLE;
    end else begin
      ts_q     <= ts_q + 1'b1;
      sample_q <= sample_i;
      expect_q <= expect_d;
      win_q    <= win_d;
      ovf_q    <= ovf_d;
      state_q  <= state_d;
    end
  end

  assign state_o    = state_q;
  assign match_o    = (state_q == ST_MATCH);
  assign stuck_o    = (state_q == ST_STUCK);
  assign overflow_o = ovf_q;

endmodule

// File: tb/tb_snap_change_logger.sv
// Directed and randomized bench for snap_change_logger against a queue-based reference model.
module tb_snap_change_logger;
  import snap_log_pkg::*;

  localparam int DW    = 8;
  localparam int TW    = 16;
  localparam int DEPTH = 4;
  localparam int LIM   = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          arm;
  logic [DW-1:0] sample;
  logic [DW-1:0] expv;
  logic          ready;
  logic          out_valid;
  logic [TW+DW-1:0] out_data;
  logic [2:0]    state;
  logic          match, stuck, ovf;

  snap_change_logger #(
    .DATA_W      (DW),
    .DEPTH       (DEPTH),
    .TS_W        (TW),
    .STUCK_LIMIT (LIM)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .arm_i       (arm),
    .sample_i    (sample),
    .expect_i    (expv),
    .out_valid_o (out_valid),
    .out_ready_i (ready),
    .out_data_o  (out_data),
    .state_o     (state),
    .match_o     (match),
    .stuck_o     (stuck),
    .overflow_o  (ovf)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: log as a queue, verdict from elapsed window cycles.
  logic [TW+DW-1:0] m_q[$];
  int               m_ts;
  logic [DW-1:0]    m_prev;
  logic [DW-1:0]    m_exp;
  int               m_state;
  int               m_age;
  bit               m_ovf;
  bit               drop_oldest;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_ts = 0; m_prev = '0; m_exp = '0; m_state = 0; m_age = 0; m_ovf = 0;
  endtask

  task automatic model_edge();
    bit full_before, popped, lost;
    full_before = (m_q.size() == DEPTH);
    popped = (m_q.size() > 0) && ready;
    lost = 0;
    if (popped) void'(m_q.pop_front());
    if (sample != m_prev) begin
      if (!full_before || popped) m_q.push_back({m_ts[TW-1:0], sample});
      else begin
        lost = 1;
        if (drop_oldest) begin
          void'(m_q.pop_front());
          m_q.push_back({m_ts[TW-1:0], sample});
        end
      end
    end
    if (arm) m_ovf = 0;
    if (lost) m_ovf = 1;
    if (arm) begin
      m_state = 1; m_exp = expv; m_age = 0;
    end else if (m_state == 1) begin
      if (sample == m_exp) m_state = 2;
      else if (m_age == LIM - 1) m_state = (sample == 0) ? 3 : 4;
      m_age++;
    end
    m_ts = (m_ts + 1) % (1 << TW);
    m_prev = sample;
  endtask

  task automatic check_all(input string tag);
    logic [TW+DW-1:0] exp_data;
    exp_data = (m_q.size() > 0) ? m_q[0] : '0;
    chk({tag, ".valid"}, 32'(out_valid), 32'(m_q.size() > 0));
    chk({tag, ".data"},  32'(out_data),  32'(exp_data));
    chk({tag, ".state"}, {27'd0, state, match, stuck},
        {27'd0, 3'(m_state), m_state == 2, m_state == 3});
    chk({tag, ".ovf"},   32'(ovf),       32'(m_ovf));
  endtask

  task automatic step(input string tag);
    model_edge();
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  task automatic do_arm(input logic [DW-1:0] e, input string tag);
    arm = 1'b1; expv = e;
    step(tag);
    arm = 1'b0;
  endtask

  initial begin
    int arm_ts;
    snap_entry_t ent;
    logic [DW-1:0] drain_first;
`ifdef SNAP_DROP_OLDEST_EN
    drop_oldest = 1;
    drain_first = 8'h02;
`else
    drop_oldest = 0;
    drain_first = 8'h01;
`endif
    rst_n = 1'b0; arm = 1'b0; sample = '0; expv = '0; ready = 1'b0;
    model_reset();
    #12;
    check_all("reset");
    #10 rst_n = 1'b1;

    // Match on the fourth cycle after arm.
    arm_ts = m_ts;
    do_arm(8'h1F, "m_arm");
    step("m_wait"); step("m_wait");
    sample = 8'h1F;
    step("m_hit");
    chk("match_state", 32'(state), 32'd2);
    ent = out_data;
    chk("match_ts", 32'(ent.ts), 32'((arm_ts + 3) % 65536));
    chk("match_val", 32'(ent.data), 32'h1F);
    ready = 1'b1;
    sample = 8'h00;
    step("m_drain"); step("m_drain"); step("m_drain");
    ready = 1'b0;

    // Stuck: sample stays at zero for the whole window.
    do_arm(8'h1F, "s_arm");
    for (int i = 0; i < LIM - 1; i++) step("s_wait");
    chk("stuck_pre", 32'(state), 32'd1);
    step("s_end");
    chk("stuck_state", {30'd0, stuck, out_valid}, {30'd0, 1'b1, 1'b0});

    // Wrong: settles on 0F.
    do_arm(8'h1F, "w_arm");
    sample = 8'h0F;
    for (int i = 0; i < LIM - 1; i++) step("w_wait");
    chk("wrong_pre", 32'(state), 32'd1);
    step("w_end");
    chk("wrong_state", 32'(state), 32'd4);
    chk("wrong_val", 32'(out_data[DW-1:0]), 32'h0F);
    ready = 1'b1; step("w_drain"); ready = 1'b0;

    // Expect zero: match on first armed cycle.
    sample = 8'h00;
    do_arm(8'h00, "z_arm");
    step("z_hit");
    chk("zero_match", 32'(state), 32'd2);
    ready = 1'b1; step("z_drain"); step("z_drain"); ready = 1'b0;

    // Overflow with five changes into a four-entry log.
    do_arm(8'hAA, "o_arm");
    for (int v = 1; v <= 5; v++) begin
      sample = 8'(v);
      step("o_fill");
    end
    chk("ovf_set", 32'(ovf), 32'd1);
    ready = 1'b1;
    for (int k = 0; k < DEPTH; k++) begin
      chk("ovf_drain", 32'(out_data[DW-1:0]), 32'(drain_first + 8'(k)));
      step("o_drain");
    end
    chk("ovf_empty", 32'(out_valid), 32'd0);
    ready = 1'b0;

    // Full with simultaneous push and pop.
    do_arm(8'hAA, "f_arm");
    for (int v = 0; v < DEPTH; v++) begin
      sample = 8'(8'h10 + v);
      step("f_fill");
    end
    ready = 1'b1; sample = 8'h20;
    step("f_pushpop");
    chk("pushpop_ovf", 32'(ovf), 32'd0);
    ready = 1'b0; sample = 8'h21;
    step("f_after");
    chk("still_full", 32'(ovf), 32'd1);
    ready = 1'b1;
    for (int k = 0; k < DEPTH + 1; k++) step("f_drain");
    ready = 1'b0;

    // Randomized traffic.
    for (int n = 0; n < 400; n++) begin
      int pick;
      pick = $urandom_range(0, 3);
      case (pick)
        0: sample = 8'h00;
        1: sample = 8'h1F;
        2: sample = m_exp;
        default: sample = 8'($urandom);
      endcase
      ready = 1'($urandom_range(0, 1));
      arm = ($urandom_range(0, 15) == 0);
      pick = $urandom_range(0, 2);
      expv = (pick == 0) ? 8'h00 : (pick == 1) ? 8'h1F : 8'($urandom);
      step("rand");
    end
    arm = 1'b0; ready = 1'b0;

    // Asynchronous reset after reaching MATCH.
    sample = 8'h33;
    do_arm(8'h33, "r_arm");
    step("r_hit");
    chk("pre_reset_match", 32'(match), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check_all("async_reset");
    sample = 8'h00;
    #3 rst_n = 1'b1;
    sample = 8'h44;
    do_arm(8'h44, "r_rearm");
    ent = out_data;
    chk("restart_ts", 32'(ent.ts), 32'd0);
    chk("restart_match", 32'(state), 32'd1);
    step("r_after");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/snap_change_logger.md
Name: snap_change_logger

Overview:
- Downstream consumer of the negedge-captured snapshot register (8-bit `{1'b0, reg[6:0]}` word) produced by the capture stage.
- Samples that word on the posedge domain and detects every change in value.
- Logs each change with a cycle timestamp into a small first-word-fall-through (FWFT) FIFO.
- Runs a verdict FSM that reports whether the register reached the expected value, stayed stuck at its reset value, or settled on a wrong value.

Parameters:
- DATA_W, 8, snapshot width.
- DEPTH, 4, log FIFO entries (power of two, ≥2).
- TS_W, 16, timestamp counter width.
- STUCK_LIMIT, 8, cycles after arm before a verdict is forced.

Ports:
- clk  input  1  single clock, posedge; the upstream negedge stage uses the same net.
- rst_n  input  1  reset, asynchronous assert, active-low.
- arm_i  input  1  one-cycle pulse; starts a verdict window.
- sample_i  input  DATA_W  snapshot from the upstream capture register.
- expect_i  input  DATA_W  expected post-update value; sampled at arm.
- out_valid_o  output  1  FIFO non-empty.
- out_ready_i  input  1  consumer pops the head when valid&ready.
- out_data_o  output  TS_W+DATA_W  head entry {ts, sample}.
- state_o  output  3  FSM state: IDLE=0, ARMED=1, MATCH=2, STUCK=3, WRONG=4.
- match_o  output  1  high in MATCH.
- stuck_o  output  1  high in STUCK.
- overflow_o  output  1  sticky: a push was attempted while full.

Behaviour:
- Reset (async, rst_n=0): sample_q=0, ts=0, FIFO empty, state IDLE, expect_q=0, win_cnt=0. All outputs 0.
- ts: free-running, +1 every cycle, wraps 2^TS_W-1→0.
- Change detect:
  - chg = (sample_i != sample_q); sample_q<=sample_i every cycle.
  - On chg, push {ts, sample_i}, using the ts value of that cycle.
  - Because sample_q resets to 0, the first nonzero sample after reset is logged.
- FIFO:
  - FWFT: out_data_o is the head whenever out_valid_o=1; out_data_o=0 when empty.
  - Pop when out_valid_o&out_ready_i.
  - Push and pop in the same cycle: both happen, and this is legal when full because the pop frees a slot.
  - Push while full with no pop: entry dropped; overflow_o<=1.
- overflow_o: cleared only by arm_i or reset.
- FSM:
  - IDLE: arm_i → ARMED; expect_q<=expect_i; win_cnt<=0; overflow_o<=0.
  - ARMED: win_cnt +1 per cycle.
    - sample_i==expect_q → MATCH. This check has priority, including on the cycle win_cnt reaches the limit.
    - Else win_cnt==STUCK_LIMIT-1 and sample_i==0 → STUCK.
    - Else win_cnt==STUCK_LIMIT-1 → WRONG.
  - MATCH/STUCK/WRONG: hold. arm_i → ARMED, with the same reloads as IDLE.
  - arm_i in ARMED: restarts the window (reload expect_q, win_cnt=0).
- Verdict latency: sample_i is compared combinationally, so the state changes on the first posedge at which the condition holds.
- Edge cases:
  - expect_i==0: MATCH on the first ARMED cycle; STUCK is unreachable.
  - Reset mid-operation: immediate return to the reset values above; FIFO contents are lost.
- Width rule: DATA_W is compared in full; no sign extension.

Optional Feature:
- SNAP_DROP_OLDEST_EN defined: push while full (no pop) overwrites the oldest entry (head advances) and overflow_o<=1, so the FIFO retains the newest DEPTH changes.
- Undefined: the newest entry is dropped and the FIFO retains the oldest DEPTH changes.
- overflow_o behaviour is identical in both builds.

Decomposition:
- Package snap_log_pkg:
  - state enum snap_state_e (3-bit, encodings above).
  - localparam defaults for DATA_W/TS_W.
  - entry struct typedef snap_entry_t {ts, data}.
- Sub-module snap_fifo: parameterised FWFT ring buffer with ptr/count, full/empty, and the SNAP_DROP_OLDEST_EN overwrite path.
- Top: change detect, ts counter, FSM.

Test Plan:
- Reset, arm with expect_i=8'h1F; sample 00 for 3 cycles, then 8'h1F → state MATCH on that edge, match_o=1, one FIFO entry {ts=arm_ts+3, 8'h1F}.
- Arm with expect_i=8'h1F; sample held 00 → STUCK exactly 8 cycles after arm, stuck_o=1, FIFO empty.
- Arm with expect 8'h1F; sample 00→8'h0F and held → WRONG after 8 cycles; one entry with data 8'h0F.
- out_ready_i=0; five distinct changes (01,02,03,04,05) → 4 entries, overflow_o=1; drain yields 01..04 (macro off) or 02..05 (macro on).
- FIFO full with push+pop in the same cycle → count stays 4, overflow_o stays 0.
- Enter MATCH, then rst_n low mid-cycle → outputs 0 and state IDLE asynchronously; next arm restarts cleanly with ts from 0.
